// File: rtl/ir_fetch_queue_if.sv
// ir_fetch_queue_if
//   Bundles the signals between the fetch queue, instruction memory, the
//   redirect sources and the decode stage.
//   Handshake rules:
//     - imem request: a fetch is transferred on a rising edge where
//       imem_req_valid && imem_req_ready. The request is driven combinationally
//       from registered state and is held while not accepted, unless a redirect
//       or reset intervenes.
//     - imem response: one word per cycle while imem_rsp_valid=1. It cannot be
//       back-pressured. Responses arrive in request order.
//     - decode slot: an instruction is consumed on a rising edge where
//       instr_valid && !stall_d. While stall_d=1 the slot is held stable.
//   Modports:
//     master : the fetch queue (drives requests and the decode slot)
//     slave  : memory / control / decode side
interface ir_fetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, stall_d
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, stall_d
  );
endinterface

// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue
//   Instruction-fetch front end. It issues word fetches, buffers the in-order
//   responses in a DEPTH-entry FIFO, and presents one {instr, pc} per cycle to
//   decode. A redirect flushes the FIFO and restarts fetch. Responses still in
//   flight at that moment are counted into 'drop' and discarded on arrival.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        ir_fetch_queue_if.master (imem req/rsp, redirect, decode slot)
//   dbg_state  current FSM state (0=BOOT, 1=RUN, 2=DRAIN)
module ir_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  ir_fetch_queue_if.master   bus,
  output logic [1:0]         dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, rsp_pc_q;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]     data_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic [CW:0]     in_use;
  logic            req_ok, accept, fifo_valid;
  logic            rsp_ret, rsp_stale, push, pop;
  logic [31:0]     redirect_base;
  logic            unused_redirect_lsb;

  assign redirect_base       = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  always_comb begin
    in_use     = {1'b0, count_q} + {1'b0, out_q};
    // Credit rule: queued + outstanding never exceeds DEPTH, so a response
    // always finds a free FIFO slot.
    req_ok     = (state_q != ST_BOOT) && !bus.redirect_valid && (in_use < DEPTH_W);
    accept     = req_ok && bus.imem_req_ready;
    fifo_valid = (count_q != '0);
    // A response with nothing outstanding cannot be ours; ignore it.
    rsp_ret    = bus.imem_rsp_valid && (out_q != '0);
    rsp_stale  = rsp_ret && (drop_q != '0);
    push       = rsp_ret && (drop_q == '0) && !bus.redirect_valid;
    pop        = fifo_valid && !bus.stall_d && !bus.redirect_valid;

    out_d = out_q + CW'(accept) - CW'(rsp_ret);
    // outstanding already includes responses previously marked for drop, so
    // after a redirect every response still to come (all of out_q minus the
    // one arriving now) is stale.
    if (bus.redirect_valid) drop_d = out_q - CW'(rsp_ret);
    else                    drop_d = drop_q - CW'(rsp_stale);
    count_d = bus.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);

    state_d = state_q;
    case (state_q)
      ST_BOOT, ST_RUN: state_d = (bus.redirect_valid && (drop_d != '0)) ? ST_DRAIN : ST_RUN;
      ST_DRAIN:        state_d = (drop_d == '0) ? ST_RUN : ST_DRAIN;
      default:         state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      if (bus.redirect_valid) begin
        fetch_pc_q <= redirect_base;
        rsp_pc_q   <= redirect_base;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        if (accept) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          rsp_pc_q <= rsp_pc_q + 32'd4;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.imem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  assign bus.imem_req_valid = req_ok;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = fifo_valid;
  assign bus.instr          = fifo_valid ? data_mem[rd_ptr_q] : NOP;
  assign bus.instr_pc       = fifo_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_ir_fetch_queue.sv
module tb_ir_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ir_fetch_queue_if bus();
  logic [1:0] dbg_state;

  ir_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Memory model: fixed latency, in order, data = addr >> 2.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc       = 0;
  int          mem_lat   = 1;
  int          mem_allow = -1;   // <0 unlimited, else responses still permitted
  int          acc_total = 0;
  int          pop_total = 0;

  // Expected PC stream
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;

  // ---------------- driver tasks ----------------
  task automatic tick(output bit acc, output logic [31:0] acc_addr,
                      output bit popped, output logic [31:0] pop_pc,
                      output logic [31:0] pop_instr);
    bit rsp_go;
    rsp_go = (mq_addr.size() > 0) && (mq_due[0] <= cyc) && (mem_allow != 0);
    bus.imem_rsp_valid = rsp_go;
    bus.imem_rsp_data  = rsp_go ? (mq_addr[0] >> 2) : 32'hDEAD_BEEF;
    #1;
    acc       = bus.imem_req_valid && bus.imem_req_ready;
    acc_addr  = bus.imem_req_addr;
    popped    = bus.instr_valid && !bus.stall_d && !bus.redirect_valid;
    pop_pc    = bus.instr_pc;
    pop_instr = bus.instr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.imem_rsp_valid = 1'b0;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      acc_total = 0;
      pop_total = 0;
    end else begin
      if (rsp_go) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
        if (mem_allow > 0) mem_allow--;
      end
      if (acc) begin
        mq_addr.push_back(acc_addr);
        mq_due.push_back(cyc - 1 + mem_lat);
        acc_total++;
      end
      if (popped) pop_total++;
    end
  endtask

  task automatic tick0();
    bit a, p;
    logic [31:0] aa, pp, pi;
    tick(a, aa, p, pp, pi);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.stall_d        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    mem_lat = 1; mem_allow = -1;
    repeat (3) tick0();
    vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
    vectors++; if (bus.instr !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", bus.instr, NOP); end
    vectors++; if (bus.instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %h expected 0", bus.instr_pc); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_basic();
    bit a, p;
    logic [31:0] aa, pp, pi, e;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    for (int t = 1; t <= 3; t++) begin
      tick(a, aa, p, pp, pi);
      if (t == 1) begin
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
          miscompares++; $display("FAIL first_request: got v=%b a=%h expected v=1 a=0", bus.imem_req_valid, bus.imem_req_addr);
        end
      end
      vectors++;
      if (bus.instr_valid !== (t == 3)) begin
        miscompares++; $display("FAIL first_valid_latency: cycle %0d got %b expected %b", t, bus.instr_valid, (t == 3));
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick(a, aa, p, pp, pi);
      e = exp_q.pop_front();
      vectors++;
      if (p !== 1'b1 || pp !== e || pi !== (e >> 2)) begin
        miscompares++; $display("FAIL basic_stream: got pop=%b pc=%h instr=%h expected pop=1 pc=%h instr=%h", p, pp, pi, e, e >> 2);
      end
    end
    next_pc = 32'd24;
  endtask

  task automatic test_stall();
    bit a, p;
    logic [31:0] aa, pp, pi, e;
    bus.stall_d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(a, aa, p, pp, pi);
      vectors++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== next_pc || bus.instr !== (next_pc >> 2)) begin
        miscompares++; $display("FAIL stall_hold: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", bus.instr_valid, bus.instr_pc, bus.instr, next_pc, next_pc >> 2);
      end
      vectors++;
      if (acc_total - pop_total > DEPTH) begin
        miscompares++; $display("FAIL stall_credit: got %0d in use expected <= %0d", acc_total - pop_total, DEPTH);
      end
    end
    vectors++;
    if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_blocks_issue: got %b expected 0", bus.imem_req_valid); end
    bus.stall_d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(a, aa, p, pp, pi);
      e = next_pc + 32'(4 * i);
      vectors++;
      if (p !== 1'b1 || pp !== e || pi !== (e >> 2)) begin
        miscompares++; $display("FAIL stall_release: got pop=%b pc=%h expected pop=1 pc=%h", p, pp, e);
      end
    end
  endtask

  task automatic test_redirect();
    bit a, p, seen;
    logic [31:0] aa, pp, pi, first_acc;
    bit got_acc;
    rst = 1'b1; tick0(); rst = 1'b0;
    bus.stall_d = 1'b1; mem_allow = 0; mem_lat = 1;
    repeat (5) tick0();           // boot + 4 accepted fetches (0,4,8,12)
    mem_allow = 1;
    tick0();                      // response for 0 queued, 3 still outstanding
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      miscompares++; $display("FAIL redirect_setup: got v=%b pc=%h expected v=1 pc=0", bus.instr_valid, bus.instr_pc);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102; bus.stall_d = 1'b0;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_no_issue: got %b expected 0", bus.imem_req_valid); end
    tick0();
    bus.redirect_valid = 1'b0; mem_allow = -1;
    vectors++;
    if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_flush: got %b expected 0", bus.instr_valid); end
    vectors++;
    if (dbg_state !== 2'd2) begin miscompares++; $display("FAIL redirect_drain: got %0d expected 2", dbg_state); end
    seen = 1'b0; got_acc = 1'b0; first_acc = 32'h0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(a, aa, p, pp, pi);
      if (a && !got_acc) begin got_acc = 1'b1; first_acc = aa; end
      seen = bus.instr_valid;
    end
    vectors++;
    if (!seen || bus.instr_pc !== 32'h100 || bus.instr !== 32'h40) begin
      miscompares++; $display("FAIL redirect_first: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=00000040", seen, bus.instr_pc, bus.instr);
    end
    vectors++;
    if (first_acc !== 32'h100) begin miscompares++; $display("FAIL redirect_fetch_addr: got %h expected 00000100", first_acc); end
    vectors++;
    if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL redirect_back_run: got %0d expected 1", dbg_state); end
    tick(a, aa, p, pp, pi);       // pops 0x100
    for (int i = 1; i <= 2; i++) begin
      tick(a, aa, p, pp, pi);
      vectors++;
      if (p !== 1'b1 || pp !== 32'(32'h100 + 4 * i)) begin
        miscompares++; $display("FAIL redirect_stream: got pop=%b pc=%h expected pop=1 pc=%h", p, pp, 32'h100 + 4 * i);
      end
    end
  endtask

  task automatic test_collide();
    bit seen;
    mem_lat = 2;
    repeat (8) tick0();
    vectors++;
    if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL collide_setup: got %b expected 1", bus.instr_valid); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
    tick0();
    bus.redirect_valid = 1'b0;
    vectors++;
    if (bus.instr_valid !== 1'b0 || dbg_state !== 2'd2) begin
      miscompares++; $display("FAIL collide_drop_one: got v=%b state=%0d expected v=0 state=2", bus.instr_valid, dbg_state);
    end
    tick0();
    vectors++;
    if (bus.instr_valid !== 1'b0 || dbg_state !== 2'd1) begin
      miscompares++; $display("FAIL collide_drained: got v=%b state=%0d expected v=0 state=1", bus.instr_valid, dbg_state);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick0();
      seen = bus.instr_valid;
    end
    vectors++;
    if (!seen || bus.instr_pc !== 32'h200 || bus.instr !== 32'h80) begin
      miscompares++; $display("FAIL collide_first: got v=%b pc=%h instr=%h expected v=1 pc=00000200 instr=00000080", seen, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_wrap();
    bit a, p;
    logic [31:0] aa, pp, pi;
    logic [31:0] accs[$];
    logic [31:0] pcs[$];
    logic [31:0] ins[$];
    mem_lat = 1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick0();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 30 && pcs.size() < 2; i++) begin
      tick(a, aa, p, pp, pi);
      if (a) accs.push_back(aa);
      if (p) begin pcs.push_back(pp); ins.push_back(pi); end
    end
    vectors++;
    if (accs.size() < 2 || accs[0] !== 32'hFFFF_FFFC || accs[1] !== 32'h0) begin
      miscompares++; $display("FAIL wrap_fetch: got %0d accepts first=%h second=%h expected fffffffc then 00000000", accs.size(), (accs.size() > 0) ? accs[0] : 32'hx, (accs.size() > 1) ? accs[1] : 32'hx);
    end
    vectors++;
    if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFFC || ins[0] !== 32'h3FFF_FFFF || pcs[1] !== 32'h0 || ins[1] !== 32'h0) begin
      miscompares++; $display("FAIL wrap_output: got %0d pops pc0=%h pc1=%h expected fffffffc/3fffffff then 00000000/00000000", pcs.size(), (pcs.size() > 0) ? pcs[0] : 32'hx, (pcs.size() > 1) ? pcs[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    bit a, p, got_acc, got_pop;
    logic [31:0] aa, pp, pi, first_acc, first_pc, first_in;
    bus.stall_d = 1'b1; mem_lat = 3;
    repeat (4) tick0();
    vectors++;
    if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL midreset_setup: got %b expected 1", bus.instr_valid); end
    rst = 1'b1;
    tick0();
    vectors++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== NOP || bus.instr_pc !== 32'h0 || dbg_state !== 2'd0) begin
      miscompares++; $display("FAIL midreset_outputs: got req=%b v=%b instr=%h pc=%h state=%0d expected 0 0 %h 0 0", bus.imem_req_valid, bus.instr_valid, bus.instr, bus.instr_pc, dbg_state, NOP);
    end
    rst = 1'b0; bus.stall_d = 1'b0; mem_lat = 1;
    got_acc = 1'b0; got_pop = 1'b0; first_acc = 32'hx; first_pc = 32'hx; first_in = 32'hx;
    for (int i = 0; i < 20 && !got_pop; i++) begin
      tick(a, aa, p, pp, pi);
      if (a && !got_acc) begin got_acc = 1'b1; first_acc = aa; end
      if (p) begin got_pop = 1'b1; first_pc = pp; first_in = pi; end
    end
    vectors++;
    if (first_acc !== 32'h0) begin miscompares++; $display("FAIL midreset_fetch: got %h expected 00000000", first_acc); end
    vectors++;
    if (!got_pop || first_pc !== 32'h0 || first_in !== 32'h0) begin
      miscompares++; $display("FAIL midreset_output: got pop=%b pc=%h instr=%h expected pop=1 pc=0 instr=0", got_pop, first_pc, first_in);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.stall_d        = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_collide();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
